// File: rtl/pipe_dest_tracker.sv
// Destination/control pipeline registers for EXE, MEM and WB feeding the forwarding unit.
// Also detects load-use hazards, inserts EXE bubbles, freezes on memory wait and counts stalls.
module pipe_dest_tracker #(
  parameter int RN_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [RN_W-1:0]  id_rn,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_flush,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             ewreg,
  output logic             em2reg,
  output logic [RN_W-1:0]  ern,
  output logic             mwreg,
  output logic             mm2reg,
  output logic [RN_W-1:0]  mrn,
  output logic             wwreg,
  output logic [RN_W-1:0]  wrn,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ewreg_q, ewreg_d;
  logic             em2reg_q, em2reg_d;
  logic [RN_W-1:0]  ern_q, ern_d;
  logic             mwreg_q, mwreg_d;
  logic             mm2reg_q, mm2reg_d;
  logic [RN_W-1:0]  mrn_q, mrn_d;
  logic             wwreg_q, wwreg_d;
  logic [RN_W-1:0]  wrn_q, wrn_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic src_hit;
  logic id_wreg_eff;
  logic exe_bubble;

  assign src_hit = (id_use_rs && (ern_q == id_rs)) || (id_use_rt && (ern_q == id_rt));
  // A flushed ID instruction never waits for an operand it will not use.
  assign lu = id_valid && !id_flush && ewreg_q && em2reg_q && (ern_q != '0) && src_hit;

  assign id_wreg_eff = id_wreg && (id_rn != '0);
  assign exe_bubble  = lu || id_flush || !id_valid;

  always_comb begin
    ewreg_d     = ewreg_q;
    em2reg_d    = em2reg_q;
    ern_d       = ern_q;
    mwreg_d     = mwreg_q;
    mm2reg_d    = mm2reg_q;
    mrn_d       = mrn_q;
    wwreg_d     = wwreg_q;
    wrn_d       = wrn_q;
    stall_cnt_d = stall_cnt_q;

    if (!mem_busy) begin
      mwreg_d  = ewreg_q;
      mm2reg_d = em2reg_q;
      mrn_d    = ern_q;
      wwreg_d  = mwreg_q;
      wrn_d    = mrn_q;
      if (exe_bubble) begin
        ewreg_d  = 1'b0;
        em2reg_d = 1'b0;
        ern_d    = '0;
      end else begin
        ewreg_d  = id_wreg_eff;
        em2reg_d = id_m2reg && id_wreg;
        // Non-writing instructions carry rn=0 so no stage shows wreg=0 with a live rn.
        ern_d    = id_wreg_eff ? id_rn : '0;
      end
      if (lu && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end

    if (cnt_clr) begin
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ewreg_q     <= 1'b0;
      em2reg_q    <= 1'b0;
      ern_q       <= '0;
      mwreg_q     <= 1'b0;
      mm2reg_q    <= 1'b0;
      mrn_q       <= '0;
      wwreg_q     <= 1'b0;
      wrn_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ewreg_q     <= ewreg_d;
      em2reg_q    <= em2reg_d;
      ern_q       <= ern_d;
      mwreg_q     <= mwreg_d;
      mm2reg_q    <= mm2reg_d;
      mrn_q       <= mrn_d;
      wwreg_q     <= wwreg_d;
      wrn_q       <= wrn_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ewreg     = ewreg_q;
  assign em2reg    = em2reg_q;
  assign ern       = ern_q;
  assign mwreg     = mwreg_q;
  assign mm2reg    = mm2reg_q;
  assign mrn       = mrn_q;
  assign wwreg     = wwreg_q;
  assign wrn       = wrn_q;
  assign stall     = lu || mem_busy;
  assign stall_cnt = stall_cnt_q;

endmodule
